// File: rtl/csa_accum_pkg.sv
// Shared types and defaults for the carry-save accumulator slice.
// Optional subtract support is enabled by defining CSA_ACCUM_SUB_EN.
package csa_accum_pkg;

    localparam int CSA_WIDTH   = 64;
    localparam int CSA_MAX_OPS = 16;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/csa_accum_producer_row.sv
// Combinational WIDTH-bit 3:2 compressor.
// Works on true (non-inverted) vectors. The carry vector is shifted left
// one place, so bit 0 is free and takes cin0 (used to finish a two's-complement
// negate). The MSB majority bit is dropped, which gives mod 2^WIDTH wrap.
module csa_row #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] x,
    input  logic             cin0,
    output logic [WIDTH-1:0] s_next,
    output logic [WIDTH-1:0] c_next
);

    logic [WIDTH-2:0] maj;

    // Bitwise sum and majority; the top majority bit would shift out, so it is never formed.
    always_comb begin
        maj    = (s[WIDTH-2:0] & c[WIDTH-2:0])
               | (s[WIDTH-2:0] & x[WIDTH-2:0])
               | (c[WIDTH-2:0] & x[WIDTH-2:0]);
        s_next = s ^ c ^ x;
        c_next = {maj, cin0};
    end

endmodule

// File: rtl/csa_accum_producer.sv
// Multi-operand carry-save accumulator with a resolved binary result.
// Optional subtract support: define CSA_ACCUM_SUB_EN to add port op_sub101H.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Operand side: op_ready101H is high only in ACCUM and never while
// reset103H is high; op_valid101H outside ACCUM is ignored and the operand
// stays with the producer. Result side: res_valid104H is high only in HOLD;
// res_ready104H is sampled only there and ignored otherwise.
module csa_accum_producer
    import csa_accum_pkg::*;
#(
    parameter int WIDTH   = CSA_WIDTH,
    parameter int MAX_OPS = CSA_MAX_OPS
) (
    input  logic             clk,
    input  logic             reset103H,
    input  logic             op_valid101H,
    output logic             op_ready101H,
    input  logic [WIDTH-1:0] op_data101H,
    input  logic             op_last101H,
`ifdef CSA_ACCUM_SUB_EN
    input  logic             op_sub101H,
`endif
    output logic [WIDTH-1:0] final_c103H,
    output logic [WIDTH-1:0] final_s103H,
    output logic [WIDTH-1:0] res104H,
    output logic             res_valid104H,
    input  logic             res_ready104H,
    output logic             forced_last104H
);

    localparam int CNT_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_OPS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] acc_s_inv;
    logic [WIDTH-1:0] acc_c_inv;
    logic [CNT_W-1:0] cnt;
    logic             forced;

    logic             accept;
    logic             cnt_hit;
    logic [WIDTH-1:0] row_x;
    logic             row_cin0;
    logic [WIDTH-1:0] row_s;
    logic [WIDTH-1:0] row_c;

    assign accept  = op_valid101H & op_ready101H;
    assign cnt_hit = (cnt == CNT_LAST);

    // Operand conditioning: subtraction is ~x plus a 1 injected into the free carry bit.
`ifdef CSA_ACCUM_SUB_EN
    always_comb begin
        row_x    = op_sub101H ? ~op_data101H : op_data101H;
        row_cin0 = op_sub101H;
    end
`else
    always_comb begin
        row_x    = op_data101H;
        row_cin0 = 1'b0;
    end
`endif

    csa_row #(.WIDTH(WIDTH)) u_row (
        .s      (~acc_s_inv),
        .c      (~acc_c_inv),
        .x      (row_x),
        .cin0   (row_cin0),
        .s_next (row_s),
        .c_next (row_c)
    );

    // State register.
    always_ff @(posedge clk or posedge reset103H) begin
        if (reset103H) state_q <= ST_ACCUM;
        else           state_q <= state_d;
    end

    // Next-state logic: close a group on last or on the operand-count limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM:   if (accept && (op_last101H || cnt_hit)) state_d = ST_RESOLVE;
            ST_RESOLVE: state_d = ST_HOLD;
            ST_HOLD:    if (res_ready104H) state_d = ST_ACCUM;
            default:    state_d = ST_ACCUM;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        op_ready101H  = (state_q == ST_ACCUM) && !reset103H;
        res_valid104H = (state_q == ST_HOLD);
    end

    // Accumulator, group counter and forced flag; RESOLVE clears them for the next group.
    always_ff @(posedge clk or posedge reset103H) begin
        if (reset103H) begin
            acc_s_inv <= '1;
            acc_c_inv <= '1;
            cnt       <= '0;
            forced    <= 1'b0;
        end else if (state_q == ST_RESOLVE) begin
            acc_s_inv <= '1;
            acc_c_inv <= '1;
            cnt       <= '0;
            forced    <= 1'b0;
        end else if (accept) begin
            acc_s_inv <= ~row_s;
            acc_c_inv <= ~row_c;
            cnt       <= cnt + 1'b1;
            if (cnt_hit && !op_last101H) forced <= 1'b1;
        end
    end

    // Snapshot and resolved result load together so res == ~c + ~s on every cycle.
    always_ff @(posedge clk or posedge reset103H) begin
        if (reset103H) begin
            final_c103H     <= '1;
            final_s103H     <= '1;
            res104H         <= '0;
            forced_last104H <= 1'b0;
        end else if (state_q == ST_RESOLVE) begin
            final_c103H     <= acc_c_inv;
            final_s103H     <= acc_s_inv;
            res104H         <= ~acc_c_inv + ~acc_s_inv;
            forced_last104H <= forced;
        end
    end

endmodule

// File: tb/tb_csa_accum_producer.sv
// Directed self-checking bench for csa_accum_producer.
// Inputs change and outputs are checked on the falling clock edge.
module tb_csa_accum_producer;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic         op_last = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] op_data = '0;
    logic         res_ready = 1'b0;

    logic         op_ready;
    logic [W-1:0] final_c;
    logic [W-1:0] final_s;
    logic [W-1:0] res;
    logic         res_valid;
    logic         forced_last;

    int n_total = 0;
    int n_pass  = 0;
    logic [W-1:0] exp_q[$];

    csa_accum_producer dut (
        .clk             (clk),
        .reset103H       (rst),
        .op_valid101H    (op_valid),
        .op_ready101H    (op_ready),
        .op_data101H     (op_data),
        .op_last101H     (op_last),
`ifdef CSA_ACCUM_SUB_EN
        .op_sub101H      (op_sub),
`endif
        .final_c103H     (final_c),
        .final_s103H     (final_s),
        .res104H         (res),
        .res_valid104H   (res_valid),
        .res_ready104H   (res_ready),
        .forced_last104H (forced_last)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Offer one operand and wait (bounded) until it is accepted.
    task automatic send_op(input logic [W-1:0] d, input logic last, input logic sub);
        bit done = 1'b0;
        int n = 0;
        op_valid = 1'b1;
        op_data  = d;
        op_last  = last;
        op_sub   = sub;
        while (!done && n < 20) begin
            done = op_ready;
            @(negedge clk);
            n++;
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        op_sub   = 1'b0;
        if (!done) chk("accept_timeout", 64'(done), 64'd1);
    endtask

    // Pulse result acceptance for one cycle in HOLD.
    task automatic ack_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("ack_valid_low", 64'(res_valid), 64'd0);
        chk("ack_ready_high", 64'(op_ready), 64'd1);
    endtask

    // Called on the falling edge right after the closing operand: check RESOLVE, then result.
    task automatic finish_group(input string tag, input logic forced_exp);
        logic [W-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_resolve_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_resolve_ready"}, 64'(op_ready), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_res"}, res, e);
        chk({tag, "_inv"}, ~final_c + ~final_s, e);
        chk({tag, "_forced"}, 64'(forced_last), 64'(forced_exp));
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(op_ready), 64'd0);
        chk("rst_res", res, 64'd0);
        chk("rst_fc", final_c, ONES);
        chk("rst_fs", final_s, ONES);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_forced", 64'(forced_last), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(op_ready), 64'd1);

        // Group {5, 7}.
        send_op(64'd5, 1'b0, 1'b0);
        exp_q.push_back(64'd12);
        send_op(64'd7, 1'b1, 1'b0);
        finish_group("g57", 1'b0);
        ack_result();

        // Reset mid-group after 3, 4 discards them and drops the old result.
        send_op(64'd3, 1'b0, 1'b0);
        send_op(64'd4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(op_ready), 64'd0);
        chk("mid_rst_res", res, 64'd0);
        @(negedge clk);
        chk("mid_rst_fc", final_c, ONES);
        chk("mid_rst_fs", final_s, ONES);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(64'd9);
        send_op(64'd9, 1'b1, 1'b0);
        finish_group("g9", 1'b0);
        ack_result();

        // Wrap: all-ones + 1 = 0.
        send_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        exp_q.push_back(64'd0);
        send_op(64'd1, 1'b1, 1'b0);
        finish_group("wrap", 1'b0);
        ack_result();

        // HOLD stall: result stable, offered operand not consumed.
        send_op(64'd100, 1'b0, 1'b0);
        exp_q.push_back(64'd123);
        send_op(64'd23, 1'b1, 1'b0);
        finish_group("g123", 1'b0);
        op_valid = 1'b1;
        op_data  = 64'd55;
        op_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_ready", 64'(op_ready), 64'd0);
            chk("hold_res", res, 64'd123);
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        ack_result();
        exp_q.push_back(64'd1);
        send_op(64'd1, 1'b1, 1'b0);
        finish_group("after_hold", 1'b0);
        ack_result();

        // Sixteen ones without last: closed by the operand limit.
        for (int i = 0; i < 15; i++) send_op(64'd1, 1'b0, 1'b0);
        exp_q.push_back(64'd16);
        send_op(64'd1, 1'b0, 1'b0);
        finish_group("forced16", 1'b1);
        ack_result();
        exp_q.push_back(64'd2);
        send_op(64'd2, 1'b1, 1'b0);
        finish_group("after_forced", 1'b0);
        ack_result();

`ifdef CSA_ACCUM_SUB_EN
        // 10 - 3 = 7.
        send_op(64'd10, 1'b0, 1'b0);
        exp_q.push_back(64'd7);
        send_op(64'd3, 1'b1, 1'b1);
        finish_group("sub7", 1'b0);
        ack_result();
        // 0 - 1 = all-ones.
        send_op(64'd0, 1'b0, 1'b0);
        exp_q.push_back(ONES);
        send_op(64'd1, 1'b1, 1'b1);
        finish_group("sub_neg1", 1'b0);
        ack_result();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
